adc_scan_ctrl: RTL and testbench

Trigger-driven conversion scheduler for the on-board 8-channel, 12-bit serial ADC (ADC128S022-type frame protocol).
- On each trigger (PWM-period sync from the vector-control loop) it scans every channel enabled in a mask in ascending order.
- It drives the ADC SPI pins directly and returns tagged 12-bit results, one strobe per channel, then a scan-done pulse.
- It sits between the ADC pins and the current/voltage measurement path of the control loop.

---
 rtl/adc_scan_ctrl.sv | 243 ++++++++++++++++++++++++
 tb/tb_adc_scan_ctrl.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/adc_scan_ctrl.sv
`default_nettype none
// adc_scan_ctrl: trigger-driven scan scheduler for an 8-channel 12-bit serial ADC
// (ADC128S022-type frames); returns tagged results and an end-of-scan pulse.  Rev 1.0
module adc_scan_ctrl #(
   parameter int CLK_DIV = 10
) (
   input  logic        CLOCK_50,
   input  logic        rst,
   input  logic        i_trig,
   input  logic [7:0]  i_ch_mask,
   output logic        ADC_CS_N,
   output logic        ADC_SCLK,
   output logic        ADC_SADDR,
   input  logic        ADC_SDAT,
   output logic [11:0] o_data,
   output logic [2:0]  o_ch,
   output logic        o_valid,
   output logic        o_done,
   output logic        o_busy,
   output logic        o_overrun
);

   localparam int            CW       = $clog2(CLK_DIV);
   localparam logic [CW-1:0] CNT_LAST = CW'(CLK_DIV - 1);

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      SETUP   = 3'd1,
      SCLK_LO = 3'd2,
      SCLK_HI = 3'd3,
      HOLD    = 3'd4
   } state_t;

   state_t           state, state_nxt;
   logic [CW-1:0]    cnt, cnt_nxt;
   logic [3:0]       bit_idx, bit_idx_nxt;
   logic [3:0]       frame, frame_nxt;
   logic [3:0]       nch, nch_nxt;
   logic [7:0][2:0]  list, list_nxt;
   logic [10:0]      shreg, shreg_nxt;
   logic             cs_n, cs_n_nxt;
   logic             sclk, sclk_nxt;
   logic             saddr, saddr_nxt;
   logic [11:0]      data, data_nxt;
   logic [2:0]       ch, ch_nxt;
   logic             valid, valid_nxt;
   logic             done, done_nxt;
   logic             busy, busy_nxt;
   logic             overrun, overrun_nxt;

   logic [7:0][2:0]  scan_list;
   logic [3:0]       scan_n;
   logic [2:0]       frame_addr;
   logic             cnt_end;

   // Compact the enabled channels into an ascending list.
   always_comb begin
      scan_list = '0;
      scan_n    = '0;
      for (int i = 0; i < 8; i++) begin
         if (i_ch_mask[i]) begin
            scan_list[scan_n[2:0]] = 3'(i);
            scan_n                 = scan_n + 4'd1;
         end
      end
   end

   // Each frame addresses the channel converted in the following frame;
   // the final frame sends address 0 only to clock out the last result.
   assign frame_addr = (frame < nch) ? list[frame[2:0]] : 3'd0;
   assign cnt_end    = (cnt == CNT_LAST);

   function automatic logic addr_bit(input logic [3:0] b, input logic [2:0] a);
      case (b)
         4'd2:    addr_bit = a[2];
         4'd3:    addr_bit = a[1];
         4'd4:    addr_bit = a[0];
         default: addr_bit = 1'b0;
      endcase
   endfunction

   always_comb begin
      state_nxt   = state;
      cnt_nxt     = cnt;
      bit_idx_nxt = bit_idx;
      frame_nxt   = frame;
      nch_nxt     = nch;
      list_nxt    = list;
      shreg_nxt   = shreg;
      cs_n_nxt    = cs_n;
      sclk_nxt    = sclk;
      saddr_nxt   = saddr;
      data_nxt    = data;
      ch_nxt      = ch;
      valid_nxt   = 1'b0;
      done_nxt    = 1'b0;
      busy_nxt    = busy;
      overrun_nxt = i_trig && (state != IDLE);

      case (state)
         IDLE: begin
            if (i_trig) begin
               if (scan_n != 4'd0) begin
                  state_nxt = SETUP;
                  list_nxt  = scan_list;
                  nch_nxt   = scan_n;
                  frame_nxt = 4'd0;
                  cnt_nxt   = '0;
                  cs_n_nxt  = 1'b0;
                  sclk_nxt  = 1'b1;
                  busy_nxt  = 1'b1;
               end else begin
                  done_nxt = 1'b1;
               end
            end
         end

         SETUP: begin
            if (cnt_end) begin
               state_nxt   = SCLK_LO;
               cnt_nxt     = '0;
               bit_idx_nxt = 4'd0;
               sclk_nxt    = 1'b0;
               saddr_nxt   = addr_bit(4'd0, frame_addr);
            end else begin
               cnt_nxt = cnt + 1'b1;
            end
         end

         SCLK_LO: begin
            if (cnt_end) begin
               state_nxt = SCLK_HI;
               cnt_nxt   = '0;
               sclk_nxt  = 1'b1;
               if (bit_idx >= 4'd4)
                  shreg_nxt = {shreg[9:0], ADC_SDAT};
               // Frame 0 carries no result: the ADC converts IN0 by default.
               if (bit_idx == 4'd15 && frame != 4'd0) begin
                  valid_nxt = 1'b1;
                  data_nxt  = {shreg, ADC_SDAT};
                  ch_nxt    = list[frame[2:0] - 3'd1];
               end
            end else begin
               cnt_nxt = cnt + 1'b1;
            end
         end

         SCLK_HI: begin
            if (cnt_end) begin
               cnt_nxt = '0;
               if (bit_idx == 4'd15) begin
                  bit_idx_nxt = 4'd0;
                  if (frame == nch) begin
                     state_nxt = HOLD;
                     cs_n_nxt  = 1'b1;
                     saddr_nxt = 1'b0;
                  end else begin
                     state_nxt = SCLK_LO;
                     frame_nxt = frame + 4'd1;
                     sclk_nxt  = 1'b0;
                     saddr_nxt = 1'b0;
                  end
               end else begin
                  state_nxt   = SCLK_LO;
                  bit_idx_nxt = bit_idx + 4'd1;
                  sclk_nxt    = 1'b0;
                  saddr_nxt   = addr_bit(bit_idx + 4'd1, frame_addr);
               end
            end else begin
               cnt_nxt = cnt + 1'b1;
            end
         end

         HOLD: begin
            if (cnt_end) begin
               state_nxt = IDLE;
               cnt_nxt   = '0;
               done_nxt  = 1'b1;
               busy_nxt  = 1'b0;
            end else begin
               cnt_nxt = cnt + 1'b1;
            end
         end

         default: begin
            state_nxt = IDLE;
            cs_n_nxt  = 1'b1;
            sclk_nxt  = 1'b1;
            busy_nxt  = 1'b0;
         end
      endcase
   end

   always_ff @(posedge CLOCK_50) begin
      if (rst) begin
         state   <= IDLE;
         cnt     <= '0;
         bit_idx <= '0;
         frame   <= '0;
         nch     <= '0;
         list    <= '0;
         shreg   <= '0;
         cs_n    <= 1'b1;
         sclk    <= 1'b1;
         saddr   <= 1'b0;
         data    <= '0;
         ch      <= '0;
         valid   <= 1'b0;
         done    <= 1'b0;
         busy    <= 1'b0;
         overrun <= 1'b0;
      end else begin
         state   <= state_nxt;
         cnt     <= cnt_nxt;
         bit_idx <= bit_idx_nxt;
         frame   <= frame_nxt;
         nch     <= nch_nxt;
         list    <= list_nxt;
         shreg   <= shreg_nxt;
         cs_n    <= cs_n_nxt;
         sclk    <= sclk_nxt;
         saddr   <= saddr_nxt;
         data    <= data_nxt;
         ch      <= ch_nxt;
         valid   <= valid_nxt;
         done    <= done_nxt;
         busy    <= busy_nxt;
         overrun <= overrun_nxt;
      end
   end

   assign ADC_CS_N  = cs_n;
   assign ADC_SCLK  = sclk;
   assign ADC_SADDR = saddr;
   assign o_data    = data;
   assign o_ch      = ch;
   assign o_valid   = valid;
   assign o_done    = done;
   assign o_busy    = busy;
   assign o_overrun = overrun;

endmodule
`default_nettype wire

// File: tb/tb_adc_scan_ctrl.sv
`default_nettype none
// tb_adc_scan_ctrl: directed + randomized scans against a behavioural ADC model
// and a protocol monitor.  Rev 1.0
module tb_adc_scan_ctrl;

   localparam int CLK_DIV = 10;

   logic        CLOCK_50 = 1'b0;
   logic        rst = 1'b1;
   logic        i_trig = 1'b0;
   logic [7:0]  i_ch_mask = 8'h00;
   logic        ADC_CS_N, ADC_SCLK, ADC_SADDR;
   logic        ADC_SDAT = 1'b0;
   logic [11:0] o_data;
   logic [2:0]  o_ch;
   logic        o_valid, o_done, o_busy, o_overrun;

   adc_scan_ctrl #(.CLK_DIV(CLK_DIV)) dut (
      .CLOCK_50  (CLOCK_50),
      .rst       (rst),
      .i_trig    (i_trig),
      .i_ch_mask (i_ch_mask),
      .ADC_CS_N  (ADC_CS_N),
      .ADC_SCLK  (ADC_SCLK),
      .ADC_SADDR (ADC_SADDR),
      .ADC_SDAT  (ADC_SDAT),
      .o_data    (o_data),
      .o_ch      (o_ch),
      .o_valid   (o_valid),
      .o_done    (o_done),
      .o_busy    (o_busy),
      .o_overrun (o_overrun)
   );

   always #10 CLOCK_50 = ~CLOCK_50;

   int n_tests = 0;
   int n_fail  = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // ADC model: latches the 3 address bits of each frame, answers in the next frame.
   logic [11:0] adc_val [8];
   logic [11:0] junk = 12'h000;
   logic [2:0]  addr_sh = 3'd0;
   logic [2:0]  got_addr [$];
   int          rise_cnt = 0;
   int          fall_cnt = 0;

   always @(negedge ADC_CS_N) begin
      rise_cnt = 0;
      fall_cnt = 0;
      got_addr.delete();
      junk = 12'($urandom);
   end

   always @(posedge ADC_SCLK) begin
      if (!ADC_CS_N) begin
         if ((rise_cnt % 16) >= 2 && (rise_cnt % 16) <= 4)
            addr_sh = {addr_sh[1:0], ADC_SADDR};
         if ((rise_cnt % 16) == 4)
            got_addr.push_back(addr_sh);
         rise_cnt++;
      end
   end

   always @(negedge ADC_SCLK) begin
      if (!ADC_CS_N) begin
         automatic int          f = fall_cnt / 16;
         automatic int          b = fall_cnt % 16;
         automatic logic [11:0] w;
         if (f == 0 || got_addr.size() < f) w = junk;
         else                              w = adc_val[got_addr[f-1]];
         ADC_SDAT = (b >= 4) ? w[15-b] : 1'b0;
         fall_cnt++;
      end
   end

   // Protocol monitor and result scoreboard.
   logic        prev_sclk = 1'b1, prev_cs = 1'b1, prev_saddr = 1'b0;
   int          run = 0;
   int          valid_cnt = 0, done_cnt = 0, ovr_cnt = 0;
   logic [2:0]  exp_ch_q [$];
   logic [11:0] exp_data_q [$];

   always @(negedge CLOCK_50) begin
      if (!ADC_CS_N && prev_cs) begin
         run = 1;
      end else if (!ADC_CS_N) begin
         if (ADC_SCLK != prev_sclk) begin
            check("sclk_half_period", run, CLK_DIV);
            run = 1;
         end else begin
            run++;
         end
         if (ADC_SADDR != prev_saddr)
            check("saddr_moves_on_fall", {prev_sclk, ADC_SCLK}, 2'b10);
      end
      if (o_valid) begin
         valid_cnt++;
         if (exp_ch_q.size() == 0) begin
            check("valid_unexpected", 1, 0);
         end else begin
            check("result_ch", o_ch, exp_ch_q.pop_front());
            check("result_data", o_data, exp_data_q.pop_front());
         end
      end
      if (o_done)    done_cnt++;
      if (o_overrun) ovr_cnt++;
      prev_sclk  = ADC_SCLK;
      prev_cs    = ADC_CS_N;
      prev_saddr = ADC_SADDR;
   end

   task automatic run_scan(input logic [7:0] m, input bit inject);
      automatic int         n = $countones(m);
      automatic int         busy_len = 0, cs_len = 0;
      automatic int         v0 = valid_cnt, d0 = done_cnt, o0 = ovr_cnt;
      automatic bit         seen = 0;
      automatic logic [2:0] ea [$];
      for (int c = 0; c < 8; c++) begin
         if (m[c]) begin
            exp_ch_q.push_back(3'(c));
            exp_data_q.push_back(adc_val[c]);
            ea.push_back(3'(c));
         end
      end
      ea.push_back(3'd0);
      i_ch_mask = m;
      i_trig    = 1'b1;
      @(negedge CLOCK_50);
      i_trig    = 1'b0;
      i_ch_mask = 8'($urandom);
      for (int cyc = 0; cyc < 4000 && !seen; cyc++) begin
         if (o_busy)    busy_len++;
         if (!ADC_CS_N) cs_len++;
         if (o_done)    seen = 1;
         if (inject)    i_trig = (cyc == 300);
         @(negedge CLOCK_50);
      end
      i_trig = 1'b0;
      check("scan_done_seen", seen, 1);
      check("busy_len", busy_len, CLK_DIV * (2 + 32 * (n + 1)));
      check("cs_low_len", cs_len, CLK_DIV * (1 + 32 * (n + 1)));
      check("valid_count", valid_cnt - v0, n);
      check("done_count", done_cnt - d0, 1);
      check("overrun_count", ovr_cnt - o0, inject ? 1 : 0);
      check("results_left", exp_ch_q.size(), 0);
      check("sclk_rises", rise_cnt, 16 * (n + 1));
      check("frames_addressed", got_addr.size(), n + 1);
      for (int k = 0; k < ea.size() && k < got_addr.size(); k++)
         check("frame_addr", got_addr[k], ea[k]);
      exp_ch_q.delete();
      exp_data_q.delete();
      repeat (3) @(negedge CLOCK_50);
   endtask

   initial begin
      automatic logic [7:0] m;
      automatic int         v0, d0;
      for (int c = 0; c < 8; c++) adc_val[c] = 12'h000;

      repeat (3) @(negedge CLOCK_50);
      check("rst_cs_n", ADC_CS_N, 1);
      check("rst_sclk", ADC_SCLK, 1);
      check("rst_saddr", ADC_SADDR, 0);
      check("rst_data", o_data, 0);
      check("rst_ch", o_ch, 0);
      check("rst_flags", {o_valid, o_done, o_busy, o_overrun}, 4'b0000);
      rst = 1'b0;
      @(negedge CLOCK_50);

      adc_val[0] = 12'hA5A;
      adc_val[2] = 12'h123;
      run_scan(8'h05, 1'b0);

      for (int c = 0; c < 8; c++) adc_val[c] = 12'(12'h100 + c);
      run_scan(8'hFF, 1'b0);

      adc_val[7] = 12'hFFF;
      run_scan(8'h80, 1'b0);

      run_scan(8'h03, 1'b1);

      // Empty mask: immediate done, no ADC activity.
      i_ch_mask = 8'h00;
      i_trig    = 1'b1;
      @(negedge CLOCK_50);
      i_trig = 1'b0;
      check("mask0_done", o_done, 1);
      check("mask0_cs_n", ADC_CS_N, 1);
      @(negedge CLOCK_50);
      check("mask0_done_pulse", o_done, 0);
      repeat (5) @(negedge CLOCK_50);
      check("mask0_idle", {ADC_CS_N, o_busy}, 2'b10);

      // Reset during frame 1 of a 0x0F scan.
      i_ch_mask = 8'h0F;
      i_trig    = 1'b1;
      @(negedge CLOCK_50);
      i_trig = 1'b0;
      for (int cyc = 0; cyc < 2000 && rise_cnt < 24; cyc++) @(negedge CLOCK_50);
      check("abort_reached_frame1", rise_cnt >= 24, 1);
      v0  = valid_cnt;
      d0  = done_cnt;
      rst = 1'b1;
      @(negedge CLOCK_50);
      check("abort_pins", {ADC_CS_N, ADC_SCLK, ADC_SADDR}, 3'b110);
      check("abort_flags", {o_valid, o_done, o_busy, o_overrun}, 4'b0000);
      check("abort_data", o_data, 0);
      rst = 1'b0;
      repeat (40) @(negedge CLOCK_50);
      check("abort_no_valid", valid_cnt - v0, 0);
      check("abort_no_done", done_cnt - d0, 0);
      check("abort_cs_idle", ADC_CS_N, 1);
      run_scan(8'h0F, 1'b0);

      repeat (6) begin
         for (int c = 0; c < 8; c++) adc_val[c] = 12'($urandom);
         m = 8'($urandom);
         if (m == 8'h00) m = 8'h01;
         run_scan(m, 1'b0);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
